// File: rtl/ifetch_buffer.sv
// Instruction-fetch buffer: accepts PCs, issues in-order memory reads, pairs
// returned words with their PCs and hands (pc, instr) to decode. A flush
// discards everything in flight; responses still owed for flushed requests
// are counted in drop_cnt and swallowed when they come back.
module ifetch_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_pc,
  output logic            in_ready,
  input  logic            flush,
  output logic            mem_req_valid,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_req_ready,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  input  logic            out_ready
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam logic [PW:0] DEPTH_W = (PW+1)'(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0]   alloc, fill, head, drop_cnt;
  logic [XLEN-1:0] slot_pc    [DEPTH];
  logic [XLEN-1:0] slot_instr [DEPTH];
  logic [DEPTH-1:0] slot_filled;

  logic [IW-1:0] alloc_idx, fill_idx, head_idx;
  logic [PW:0]   occupancy;
  logic [PW:0]   flush_drop_sum;
  logic [PW:0]   flush_drop;
  logic          credit, accept, pop, resp_drop, resp_fill;

  assign alloc_idx = alloc[IW-1:0];
  assign fill_idx  = fill[IW-1:0];
  assign head_idx  = head[IW-1:0];

  // Occupancy counts slots from head to alloc plus responses still owed for
  // flushed requests. It is taken before this cycle's pop, so space freed by
  // a pop becomes available to the PC stage on the following cycle.
  assign occupancy = {1'b0, PW'(alloc - head)} + {1'b0, drop_cnt};
  assign credit    = occupancy < DEPTH_W;

  assign mem_req_valid = in_valid & credit & ~flush & ~reset;
  assign mem_req_addr  = in_pc;
  assign in_ready      = credit & mem_req_ready & ~flush & ~reset;
  assign accept        = in_valid & in_ready;

  // Filled bits are cleared on pop, so a set bit at head always belongs to a
  // live entry and never to a stale one from a previous lap.
  assign out_valid = slot_filled[head_idx] & ((head != fill) | slot_filled[head_idx]) & ~reset;
  assign out_pc    = slot_pc[head_idx];
  assign out_instr = slot_instr[head_idx];
  assign pop       = out_valid & out_ready & ~flush;

  // A response with nothing outstanding (fill == alloc, drop_cnt == 0) is ignored.
  assign resp_drop = mem_resp_valid & (drop_cnt != '0);
  assign resp_fill = mem_resp_valid & (drop_cnt == '0) & (fill != alloc);

  // On flush every outstanding request becomes owed; a response arriving in
  // the same cycle pays one back immediately.
  assign flush_drop_sum = {1'b0, drop_cnt} + {1'b0, PW'(alloc - fill)};
  assign flush_drop     = (mem_resp_valid && (flush_drop_sum != '0)) ? flush_drop_sum - 1'b1
                                                                   : flush_drop_sum;

  // Pointer, drop counter and filled-bit control.
  always_ff @(posedge clock) begin
    if (reset) begin
      alloc       <= '0;
      fill        <= '0;
      head        <= '0;
      drop_cnt    <= '0;
      slot_filled <= '0;
    end else if (flush) begin
      fill        <= alloc;
      head        <= alloc;
      drop_cnt    <= flush_drop[PW-1:0];
      slot_filled <= '0;
    end else begin
      if (accept) begin
        alloc                  <= alloc + 1'b1;
        slot_filled[alloc_idx] <= 1'b0;
      end
      if (resp_drop) drop_cnt <= drop_cnt - 1'b1;
      if (resp_fill) begin
        fill                  <= fill + 1'b1;
        slot_filled[fill_idx] <= 1'b1;
      end
      if (pop) begin
        head                  <= head + 1'b1;
        slot_filled[head_idx] <= 1'b0;
      end
    end
  end

  // Slot payload storage; validity is tracked solely by slot_filled.
  always_ff @(posedge clock) begin
    if (accept) slot_pc[alloc_idx] <= in_pc;
    if (resp_fill && !flush && !reset) slot_instr[fill_idx] <= mem_resp_data;
  end

endmodule

// File: tb/tb_ifetch_buffer.sv
// Bench for ifetch_buffer: directed scenarios followed by random traffic, all
// cycles checked against a queue-based reference model and an in-order
// memory model with configurable latency.
module tb_ifetch_buffer;
  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  logic clock = 1'b0;
  logic reset, in_valid, in_ready, flush, mem_req_valid, mem_req_ready;
  logic mem_resp_valid, out_valid, out_ready;
  logic [XLEN-1:0] in_pc, mem_req_addr, mem_resp_data, out_pc, out_instr;

  always #5 clock = ~clock;

  ifetch_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_pc(in_pc), .in_ready(in_ready),
    .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_ready(out_ready)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mem_lat = 1;
  int last_due = 0;

  // Reference model: entries from oldest to youngest; the first m_nfilled have data.
  logic [31:0] m_pc[$];
  logic [31:0] m_instr[$];
  int m_nfilled = 0;
  int m_drop = 0;

  // Memory model: pending responses in order.
  int mq_due[$];
  logic [31:0] mq_data[$];

  logic [31:0] got_pc[$];
  logic acc_seen;
  int accepts;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h0050_0193;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic credit, e_in_ready, e_req_valid, e_out_valid, acc, pop;
    int due;
    if (!reset && mq_due.size() > 0 && mq_due[0] <= cyc) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = mq_data[0];
      void'(mq_due.pop_front());
      void'(mq_data.pop_front());
    end else begin
      mem_resp_valid = 1'b0;
      mem_resp_data  = $urandom;
    end
    #1;
    credit      = (m_pc.size() + m_drop) < DEPTH;
    e_in_ready  = credit && mem_req_ready && !flush && !reset;
    e_req_valid = in_valid && credit && !flush && !reset;
    e_out_valid = !reset && (m_nfilled > 0);
    check("in_ready", 32'(in_ready), 32'(e_in_ready));
    check("mem_req_valid", 32'(mem_req_valid), 32'(e_req_valid));
    if (e_req_valid) check("mem_req_addr", mem_req_addr, in_pc);
    check("out_valid", 32'(out_valid), 32'(e_out_valid));
    if (e_out_valid) begin
      check("out_pc", out_pc, m_pc[0]);
      check("out_instr", out_instr, m_instr[0]);
    end
    acc = in_valid && e_in_ready;
    pop = e_out_valid && out_ready && !flush;
    acc_seen = acc;
    if (out_valid && out_ready && !flush) got_pc.push_back(out_pc);

    if (reset) begin
      m_pc.delete(); m_instr.delete();
      m_nfilled = 0; m_drop = 0;
      mq_due.delete(); mq_data.delete();
      last_due = 0;
    end else if (flush) begin
      m_drop = m_drop + (m_pc.size() - m_nfilled) - (mem_resp_valid ? 1 : 0);
      if (m_drop < 0) m_drop = 0;
      m_pc.delete(); m_instr.delete();
      m_nfilled = 0;
    end else begin
      if (mem_resp_valid) begin
        if (m_drop > 0) m_drop--;
        else if (m_nfilled < m_pc.size()) begin
          m_instr[m_nfilled] = mem_resp_data;
          m_nfilled++;
        end
      end
      if (pop) begin
        void'(m_pc.pop_front());
        void'(m_instr.pop_front());
        m_nfilled--;
      end
      if (acc) begin
        m_pc.push_back(in_pc);
        m_instr.push_back(32'h0);
        due = cyc + mem_lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mq_due.push_back(due);
        mq_data.push_back(mem_word(in_pc));
      end
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_pc = '0; flush = 1'b0;
    mem_req_ready = 1'b1; out_ready = 1'b1;
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    tick(); tick();
    reset = 1'b0;

    // Single fetch with 1-cycle memory.
    mem_lat = 1; in_valid = 1'b1; in_pc = 32'h100;
    tick();
    check("t1_accept", 32'(acc_seen), 32'd1);
    in_valid = 1'b0;
    tick();
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_pc", out_pc, 32'h100);
    check("t1_instr", out_instr, 32'h0050_0093);
    tick(); tick();

    // Stream of four sequential PCs.
    got_pc.delete();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 32'(i * 4);
      for (int k = 0; k < 10; k++) begin
        tick();
        if (acc_seen) break;
      end
      check("t2_accept", 32'(acc_seen), 32'd1);
    end
    in_valid = 1'b0;
    repeat (6) tick();
    check("t2_count", 32'(got_pc.size()), 32'd4);
    for (int i = 0; i < got_pc.size(); i++) check("t2_order", got_pc[i], 32'(i * 4));

    // Backpressure from decode.
    got_pc.delete();
    out_ready = 1'b0; accepts = 0; in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_pc = 32'h300 + 32'(accepts * 4);
      tick();
      if (acc_seen) accepts++;
    end
    check("t3_accepts", 32'(accepts), 32'd2);
    check("t3_full", 32'(in_ready), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("t3_ready_after_pop", 32'(in_ready), 32'd1);
    repeat (4) tick();
    check("t3_count", 32'(got_pc.size()), 32'd2);

    // Flush with two outstanding requests on a 3-cycle memory.
    repeat (3) tick();
    got_pc.delete();
    mem_lat = 3; in_valid = 1'b1; in_pc = 32'h400;
    tick();
    check("t4_acc0", 32'(acc_seen), 32'd1);
    in_pc = 32'h404;
    tick();
    check("t4_acc1", 32'(acc_seen), 32'd1);
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b1; in_pc = 32'h200;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (acc_seen) break;
    end
    check("t4_acc_new", 32'(acc_seen), 32'd1);
    in_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (out_valid) break;
      tick();
    end
    check("t4_valid", 32'(out_valid), 32'd1);
    check("t4_pc", out_pc, 32'h200);
    check("t4_instr", out_instr, mem_word(32'h200));
    tick();
    check("t4_count", 32'(got_pc.size()), 32'd1);

    // Flush in the same cycle as a response.
    repeat (6) tick();
    got_pc.delete();
    mem_lat = 2; in_valid = 1'b1; in_pc = 32'h500;
    tick();
    in_pc = 32'h504;
    tick();
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (6) tick();
    check("t5_no_output", 32'(got_pc.size()), 32'd0);
    check("t5_idle", 32'(out_valid), 32'd0);

    // Reset with one buffered and one outstanding entry.
    out_ready = 1'b0; mem_lat = 1; in_valid = 1'b1; in_pc = 32'h600;
    tick();
    mem_lat = 4; in_pc = 32'h604;
    tick();
    in_valid = 1'b0;
    check("t6_buffered", 32'(out_valid), 32'd1);
    reset = 1'b1;
    tick();
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_ready", 32'(in_ready), 32'd0);
    reset = 1'b0; out_ready = 1'b1;
    #1;
    check("t6_ready", 32'(in_ready), 32'd1);
    check("t6_empty", 32'(out_valid), 32'd0);
    repeat (6) tick();

    // Random traffic.
    for (int n = 0; n < 800; n++) begin
      reset         = ($urandom_range(0, 199) == 0);
      flush         = ($urandom_range(0, 19) == 0);
      in_valid      = ($urandom_range(0, 3) != 0);
      in_pc         = $urandom & 32'hFFFF_FFFC;
      out_ready     = ($urandom_range(0, 3) != 0);
      mem_req_ready = ($urandom_range(0, 4) != 0);
      if (n % 100 == 0) mem_lat = $urandom_range(1, 4);
      tick();
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; mem_req_ready = 1'b1;
    repeat (8) tick();
    check("final_empty", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
